// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register.
// Holds a packed stage payload. Whenever the stage is empty, the upper payload
// bits carry NOP_VAL and the low KEEP_W bits (the PC field) keep the last PC seen.
// A flush empties the stage and may load a new PC into the low field.
// With SKID=1 the stage has one extra skid entry, so in_ready comes from a register.
// Three saturating counters (stall, bubble, flush) support performance analysis.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = 32,
  parameter logic [((DATA_W > KEEP_W) ? (DATA_W - KEEP_W) : 1)-1:0] NOP_VAL = '0,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Low-field mask and the NOP pattern, both placed in a full-width word
  localparam logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b1}} >> (DATA_W - KEEP_W);
  localparam logic [DATA_W-1:0] NOP_WORD  =
    (DATA_W > KEEP_W) ? (DATA_W'(NOP_VAL) << KEEP_W) : {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   main_r, main_nxt_s;
  logic [DATA_W-1:0]   skid_r, skid_nxt_s;
  logic                valid_r;
  logic                in_ready_r;
  logic                in_ready_s;
  logic                in_xfer_s;
  logic                out_xfer_s;
  logic [CNT_W-1:0]    stall_cnt_r, bubble_cnt_r, flush_cnt_r;

  // Bubble word: NOP in the upper field, low field taken from the given source
  function automatic logic [DATA_W-1:0] to_bubble(input logic [DATA_W-1:0] low_src);
    return (low_src & KEEP_MASK) | NOP_WORD;
  endfunction

  // Counter step that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt != {CNT_W{1'b1}}) begin
      return cnt + CNT_W'(1);
    end else begin
      return cnt;
    end
  endfunction

  // Without a skid entry, ready must follow out_ready in the same cycle
  assign in_ready_s = (SKID != 0) ? in_ready_r : (out_ready | ~valid_r);
  // A flush cycle never accepts the incoming payload as valid
  assign in_xfer_s  = in_valid & in_ready_s & ~flush;
  assign out_xfer_s = valid_r & out_ready;

  assign in_ready   = in_ready_s;
  assign out_valid  = valid_r;
  assign out_data   = main_r;
  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;

  // Next-state and datapath selection; flush overrides every other event
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      skid_nxt_s  = {DATA_W{1'b0}};
      if (in_valid) begin
        main_nxt_s = to_bubble(in_data);
      end else begin
        main_nxt_s = to_bubble(main_r);
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_nxt_s = in_data;
          end else if (in_xfer_s) begin
            // Only reachable with a skid entry; without one ready implies out_ready
            if (SKID != 0) begin
              skid_nxt_s  = in_data;
              state_nxt_s = ST_TWO;
            end else begin
              main_nxt_s = in_data;
            end
          end else if (out_xfer_s) begin
            main_nxt_s  = to_bubble(main_r);
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_xfer_s) begin
            main_nxt_s  = skid_r;
            skid_nxt_s  = {DATA_W{1'b0}};
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = to_bubble(main_r);
          skid_nxt_s  = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // Stage state, payload registers and the registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      main_r     <= NOP_WORD;
      skid_r     <= {DATA_W{1'b0}};
      valid_r    <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      main_r     <= main_nxt_s;
      skid_r     <= skid_nxt_s;
      valid_r    <= (state_nxt_s != ST_EMPTY);
      in_ready_r <= (state_nxt_s != ST_TWO);
    end
  end

  // Performance counters, sampled on the current-cycle handshake and flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (valid_r && !out_ready) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (!valid_r && out_ready) begin
        bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end
      if (flush) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid stage, one single-register
// stage and one skid stage with 4-bit counters, all driven by shared inputs.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int KW = 32;
  localparam logic [31:0] NOP = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = 64'h0;

  logic          ir1, ov1, ir0, ov0, ir4, ov4;
  logic [DW-1:0] od1, od0, od4;
  logic [15:0]   sc1, bc1, fc1, sc0, bc0, fc0;
  logic [3:0]    sc4, bc4, fc4;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .KEEP_W(KW), .NOP_VAL(NOP), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .stall_cnt(sc1), .bubble_cnt(bc1), .flush_cnt(fc1));

  pipe_stage_reg #(.DATA_W(DW), .KEEP_W(KW), .NOP_VAL(NOP), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .stall_cnt(sc0), .bubble_cnt(bc0), .flush_cnt(fc0));

  pipe_stage_reg #(.DATA_W(DW), .KEEP_W(KW), .NOP_VAL(NOP), .SKID(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .stall_cnt(sc4), .bubble_cnt(bc4), .flush_cnt(fc4));

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pl(input int i);
    return {32'h1000_0000 + 32'(i), 32'(i)};
  endfunction

  // Directed scenario sequence
  initial begin
    // Asynchronous reset arriving mid-cycle while the stage holds a payload
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = pl(1); out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(ov1), 64'h1);
    tick();
    check("pre_rst_stall", 64'(sc1), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 64'(ov1), 64'h0);
    check("rst_data", od1, {NOP, 32'h0});
    check("rst_ready", 64'(ir1), 64'h1);
    check("rst_cnt", {sc1, bc1, fc1, 16'h0}, 64'h0);
    check("rst_cnt0", {sc0, bc0, fc0, 16'h0}, 64'h0);
    check("rst_dut4", {ov4, ir4, sc4, bc4, fc4}, {1'b0, 1'b1, 12'h0});
    tick();
    rst = 1'b0;

    // Back-to-back stream 1..8 with out_ready held high, both structures
    out_ready = 1'b1; in_valid = 1'b1; in_data = pl(1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("stream_v", 64'(ov1), 64'h1);
      check("stream_d", od1, pl(i));
      check("stream_v0", 64'(ov0), 64'h1);
      check("stream_d0", od0, pl(i));
      check("stream_rdy0", 64'(ir0), 64'h1);
      if (i < 8) begin
        in_data = pl(i + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stream_bubble", 64'(bc1), 64'h1);
    check("stream_bubble0", 64'(bc0), 64'h1);
    tick();
    check("drain_v", 64'(ov1), 64'h0);
    check("drain_d", od1, {NOP, 32'h8});
    check("drain_d0", od0, {NOP, 32'h8});
    out_ready = 1'b0;

    // Backpressure on the skid stage: 2 parks in the skid, 3 waits upstream
    in_valid = 1'b1; in_data = pl(1);
    tick();
    check("bp_d1", od1, pl(1));
    check("bp_rdy1", 64'(ir1), 64'h1);
    in_data = pl(2);
    tick();
    check("bp_hold_d", od1, pl(1));
    check("bp_full_rdy", 64'(ir1), 64'h0);
    check("bp_stall1", 64'(sc1), 64'h1);
    in_data = pl(3);
    tick();
    check("bp_stall2", 64'(sc1), 64'h2);
    check("bp_hold_d2", od1, pl(1));
    out_ready = 1'b1;
    tick();
    check("bp_d2", od1, pl(2));
    check("bp_rdy2", 64'(ir1), 64'h1);
    tick();
    check("bp_d3", od1, pl(3));
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(ov1), 64'h0);
    check("bp_stall_end", 64'(sc1), 64'h2);

    // Flush with the skid stage full and a new PC arriving
    out_ready = 1'b0; in_valid = 1'b1; in_data = pl(10);
    tick();
    in_data = pl(11);
    tick();
    check("fl_full", 64'(ir1), 64'h0);
    flush = 1'b1; in_data = {32'h1234_5678, 32'hBFC0_0380};
    tick();
    check("fl_valid", 64'(ov1), 64'h0);
    check("fl_data", od1, {NOP, 32'hBFC0_0380});
    check("fl_ready", 64'(ir1), 64'h1);
    check("fl_cnt", 64'(fc1), 64'h1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_after_v", 64'(ov1), 64'h0);
    check("fl_after_d", od1, {NOP, 32'hBFC0_0380});

    // Flush wins over a simultaneous output transfer; held flush tracks PC
    in_valid = 1'b1; in_data = pl(12); out_ready = 1'b1;
    tick();
    check("fw_loaded", 64'(ov1), 64'h1);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    check("fw_valid", 64'(ov1), 64'h0);
    check("fw_data", od1, {NOP, 32'd12});
    check("fw_cnt", 64'(fc1), 64'h2);
    in_valid = 1'b1; in_data = {32'hFFFF_FFFF, 32'h0000_1111};
    tick();
    check("fh_valid", 64'(ov1), 64'h0);
    check("fh_data", od1, {NOP, 32'h0000_1111});
    check("fh_cnt", 64'(fc1), 64'h3);
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Stall counter saturation with 4-bit counters
    #2 rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = pl(5);
    tick();
    in_valid = 1'b0;
    check("sat_v4", 64'(ov4), 64'h1);
    check("sat_d4", od4, pl(5));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) begin
        check("sat_at15", 64'(sc4), 64'hF);
      end
      if (k == 20) begin
        check("sat_at20", 64'(sc4), 64'hF);
        check("wide_at20", 64'(sc1), 64'd20);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
